// File: rtl/hierarchy_seq_pkg.sv
// Shared definitions for the hierarchy_seq pipeline: operation mode encodings and counter width.
package hierarchy_seq_pkg;

    typedef enum logic [1:0] {
        MODE_AND = 2'd0,
        MODE_OR  = 2'd1,
        MODE_XOR = 2'd2,
        MODE_ADD = 2'd3
    } mode_t;

    localparam int CNT_WIDTH = 16;

endpackage

// File: rtl/hierarchy_seq_stage.sv
// One pipeline register stage: a valid bit plus data word, loaded from the previous stage when enabled.
module hierarchy_seq_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= prev_valid;
            data  <= prev_data;
        end
    end

endmodule

// File: rtl/hierarchy_seq_pipe.sv
// Valid/ready pipeline of DEPTH stages computing AND/OR/XOR/ADD on entry.
// Define HIERARCHY_SEQ_SAT_EN to make ADD saturate to all-ones on carry-out instead of wrapping.
module hierarchy_seq_pipe
    import hierarchy_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     c,
    output logic [CNT_WIDTH-1:0] out_cnt
);

    logic [WIDTH-1:0]     op_result;
    logic [DEPTH-1:0]     valid;
    logic [DEPTH-1:0]     load;
    logic [WIDTH-1:0]     data [DEPTH];
    logic [CNT_WIDTH-1:0] cnt_reg;

`ifdef HIERARCHY_SEQ_SAT_EN
    logic [WIDTH:0] sum;

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        op_result = '0;
        case (mode_t'(mode))
            MODE_AND: op_result = a & b;
            MODE_OR:  op_result = a | b;
            MODE_XOR: op_result = a ^ b;
            MODE_ADD: op_result = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
            default:  op_result = '0;
        endcase
    end
`else
    always_comb begin
        op_result = '0;
        case (mode_t'(mode))
            MODE_AND: op_result = a & b;
            MODE_OR:  op_result = a | b;
            MODE_XOR: op_result = a ^ b;
            MODE_ADD: op_result = a + b;
            default:  op_result = '0;
        endcase
    end
`endif

    // A stage can load when any stage from it to the output is empty, or the output drains.
    // Written flat rather than as a ripple chain so the enable never feeds back on itself.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            assign load[gi] = out_ready || !(&valid[DEPTH-1:gi]);

            if (gi == 0) begin : g_first
                hierarchy_seq_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk        (clk),
                    .rst_n      (rst_n),
                    .load       (load[gi]),
                    .prev_valid (in_valid),
                    .prev_data  (op_result),
                    .valid      (valid[gi]),
                    .data       (data[gi])
                );
            end else begin : g_rest
                hierarchy_seq_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk        (clk),
                    .rst_n      (rst_n),
                    .load       (load[gi]),
                    .prev_valid (valid[gi-1]),
                    .prev_data  (data[gi-1]),
                    .valid      (valid[gi]),
                    .data       (data[gi])
                );
            end
        end
    endgenerate

    assign in_ready  = load[0];
    assign out_valid = valid[DEPTH-1];
    assign c         = data[DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (out_valid && out_ready) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign out_cnt = cnt_reg;

endmodule

// File: tb/tb_hierarchy_seq_pipe.sv
// Scoreboard bench for hierarchy_seq_pipe (WIDTH=8, DEPTH=3): directed cases plus randomized traffic.
module tb_hierarchy_seq_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [1:0]  mode = '0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  c;
    logic [15:0] out_cnt;

    hierarchy_seq_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] val;
        int         acc;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       popped;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         cnt_model = 0;
    int         last_lat = 0;
    logic [7:0] last_c = '0;
    bit         held = 1'b0;
    logic [7:0] held_c = '0;
    bit         lat_check_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_op(input logic [1:0] m, input logic [7:0] x, input logic [7:0] y);
        int s;
        case (m)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: begin
                s = int'(x) + int'(y);
`ifdef HIERARCHY_SEQ_SAT_EN
                if (s > 255) return 8'hFF;
`endif
                return 8'(s % 256);
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each delivered beat and checks hold-while-stalled.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_c", c, held_c);
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_beat actual c=0x%0h expected no beat", c);
                    end else begin
                        popped = sb_q.pop_front();
                        check("data", c, popped.val);
                        check("out_cnt_at_delivery", out_cnt, cnt_model[15:0]);
                        last_lat = cyc - popped.acc;
                        last_c   = c;
                        if (lat_check_en) check("latency", last_lat, DEPTH);
                    end
                    cnt_model++;
                    $display("deliver c=0x%02h out_cnt=%0d", c, out_cnt);
                end
                held   = out_valid && !out_ready;
                held_c = c;
            end
        end
    end

    task automatic step(input bit iv, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [1:0] im, input bit ordy, output bit acc);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        mode      = im;
        out_ready = ordy;
        #1;
        acc = iv && in_ready;
        if (acc) begin
            sb_q.push_back('{ref_op(im, ia, ib), cyc});
            $display("accept a=0x%02h b=0x%02h mode=%0d", ia, ib, im);
        end
    endtask

    task automatic drain(input int budget);
        bit acc;
        for (int i = 0; i < budget; i++) begin
            if (sb_q.size() == 0) break;
            step(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, acc);
        end
        check("drain_remaining", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sa [4];
        logic [7:0] sb [4];
        logic [1:0] sm [4];
        bit         acc;
        int         nacc;

        sa = '{8'hFF, 8'h01, 8'hAA, 8'h55};
        sb = '{8'h0F, 8'h02, 8'h0F, 8'h55};
        sm = '{2'd2,  2'd1,  2'd0,  2'd2};

        // Reset with busy inputs
        rst_n = 1'b0; in_valid = 1'b1; a = 8'hA5; b = 8'h5A; mode = 2'd3; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        check("reset_out_valid", out_valid, 0);
        check("reset_c", c, 8'h00);
        check("reset_out_cnt", out_cnt, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_in_ready", in_ready, 1);

        // Streaming, four back-to-back beats
        lat_check_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, sa[i], sb[i], sm[i], 1'b1, acc);
            check("stream_accept", acc, 1);
        end
        drain(20);
        check("stream_out_cnt", out_cnt, 16'd4);

        // Latency of a single AND beat
        step(1'b1, 8'hF0, 8'h3C, 2'd0, 1'b1, acc);
        check("lat_accept", acc, 1);
        drain(20);
        check("lat_c", last_c, 8'h30);
        check("lat_cycles", last_lat, 3);
        lat_check_en = 1'b0;

        // Full backpressure: only DEPTH beats fit
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, acc);
            nacc += int'(acc);
        end
        check("bp_accepted", nacc, 3);
        check("bp_in_ready", in_ready, 0);
        drain(20);

        // ADD carry behaviour
        step(1'b1, 8'hC8, 8'h64, 2'd3, 1'b1, acc);
        drain(20);
`ifdef HIERARCHY_SEQ_SAT_EN
        check("add_c", last_c, 8'hFF);
`else
        check("add_c", last_c, 8'h2C);
`endif

        // Randomized traffic with random stalls on both sides
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom), 2'($urandom),
                 $urandom_range(0, 9) < 6, acc);
        end
        drain(100);
        check("random_out_cnt", out_cnt, cnt_model[15:0]);

        // Reset with two beats in flight
        step(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, acc);
        step(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        sb_q.delete();
        cnt_model = 0;
        #2;
        check("midrst_out_valid_low", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00, 8'h00, 2'd0, 1'b1, acc);
            check("midrst_no_out_valid", out_valid, 0);
        end
        check("midrst_out_cnt", out_cnt, 16'h0000);
        check("midrst_in_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
